cu_seq: RTL and testbench



---
 rtl/cu_pkg.sv | 64 ++++++
 rtl/cu_seq.sv | 161 ++++++++++++++++
 tb/tb_cu_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the cu_seq control unit: states, opcodes, ALU modes
// and datapath mux selects.
package cu_pkg;

  typedef enum logic [7:0] {
    S_FETCH0 = 8'd0,
    S_FETCH1 = 8'd1,
    S_FETCH2 = 8'd2,
    S_DECODE = 8'd3,
    S_EXEC   = 8'd4,
    S_OPER0  = 8'd5,
    S_OPER1  = 8'd6,
    S_MEM0   = 8'd7,
    S_MEM1   = 8'd8,
    S_WB     = 8'd9,
    S_JUMP   = 8'd10,
    S_SKIP   = 8'd11,
    S_HALT   = 8'd12
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_MVA = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] MODE_ADD  = 3'd0;
  localparam logic [2:0] MODE_SUB  = 3'd1;
  localparam logic [2:0] MODE_AND  = 3'd2;
  localparam logic [2:0] MODE_OR   = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_PASS = 3'd5;

  localparam logic MAR_PC    = 1'b0;
  localparam logic MAR_MBR   = 1'b1;
  localparam logic MBR_RAM   = 1'b0;
  localparam logic MBR_ACC   = 1'b1;
  localparam logic ALU_RF    = 1'b0;
  localparam logic ALU_MBR   = 1'b1;
  localparam logic RF_ACC    = 1'b0;
  localparam logic RF_MBR    = 1'b1;
  localparam logic AOUT_ALU  = 1'b0;
  localparam logic AOUT_OPND = 1'b1;

  function automatic logic [2:0] alu_mode(input logic [3:0] opc);
    case (opc)
      OP_SUB:  alu_mode = MODE_SUB;
      OP_AND:  alu_mode = MODE_AND;
      OP_OR:   alu_mode = MODE_OR;
      OP_XOR:  alu_mode = MODE_XOR;
      default: alu_mode = MODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cu_seq.sv
// Multi-cycle control unit: fetch/decode/operand/execute/write-back sequencing
// with RAM wait states, conditional branches and halt/illegal trapping.
module cu_seq
  import cu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int SEL_W  = 2
) (
  input  logic              cu_clk,
  input  logic              cu_rst,
  input  logic [DATA_W-1:0] cu_in,
  input  logic              zero,
  input  logic              carry,
  input  logic              mem_ready,
  output logic [2:0]        mode,
  output logic [SEL_W-1:0]  select,
  output logic [7:0]        state,
  output logic              MBR_we,
  output logic              IR_we,
  output logic              PC_inc,
  output logic              PC_ld,
  output logic              RF_we,
  output logic              Acc_we,
  output logic              MAR_we,
  output logic              RAM_we,
  output logic              ALU_mux,
  output logic              RF_mux,
  output logic              ALU_out_mux,
  output logic              MAR_mux,
  output logic              MBR_mux,
  output logic              halted,
  output logic              illegal
);

  state_t             r_state;
  logic [OPC_W-1:0]   r_opc;
  logic [SEL_W-1:0]   r_sel;
  logic               r_halted;
  logic               r_illegal;

  logic [3:0] w_op;
  logic       w_jump;
  logic       w_alu;
  logic       w_unused_in;

  assign w_op        = r_opc[3:0];
  assign w_jump      = (w_op == OP_JMP) || (w_op == OP_JZ) || (w_op == OP_JC);
  assign w_alu       = (w_op >= OP_ADD) && (w_op <= OP_XOR);
  assign w_unused_in = ^cu_in;

  always_ff @(posedge cu_clk) begin
    if (cu_rst) begin
      r_state   <= S_FETCH0;
      r_opc     <= '0;
      r_sel     <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH0: r_state <= S_FETCH1;
        S_FETCH1: if (mem_ready) r_state <= S_FETCH2;
        S_FETCH2: begin
          r_opc   <= cu_in[DATA_W-1 -: OPC_W];
          r_sel   <= cu_in[SEL_W-1:0];
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (w_op)
            OP_NOP:                          r_state <= S_FETCH0;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_MOV, OP_MVA:          r_state <= S_EXEC;
            OP_LDA, OP_STA, OP_JMP:          r_state <= S_OPER0;
            OP_JZ:  r_state <= zero  ? S_OPER0 : S_SKIP;
            OP_JC:  r_state <= carry ? S_OPER0 : S_SKIP;
            OP_HLT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: begin
              r_state   <= S_HALT;
              r_halted  <= 1'b1;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_OPER0: r_state <= S_OPER1;
        S_OPER1: if (mem_ready) r_state <= w_jump ? S_JUMP : S_MEM0;
        S_MEM0:  r_state <= S_MEM1;
        S_MEM1:  if (mem_ready) r_state <= (w_op == OP_LDA) ? S_WB : S_FETCH0;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH0;
      endcase
    end
  end

  // PC_inc in the wait states follows mem_ready so each byte bumps PC once.
  always_comb begin
    mode        = MODE_ADD;
    MBR_we      = 1'b0;
    IR_we       = 1'b0;
    PC_inc      = 1'b0;
    PC_ld       = 1'b0;
    RF_we       = 1'b0;
    Acc_we      = 1'b0;
    MAR_we      = 1'b0;
    RAM_we      = 1'b0;
    ALU_mux     = ALU_RF;
    RF_mux      = RF_ACC;
    ALU_out_mux = AOUT_ALU;
    MAR_mux     = MAR_PC;
    MBR_mux     = MBR_RAM;
    if (!cu_rst) begin
      case (r_state)
        S_FETCH0, S_OPER0: MAR_we = 1'b1;
        S_FETCH1, S_OPER1: begin
          MBR_we = 1'b1;
          PC_inc = mem_ready;
        end
        S_FETCH2: IR_we = 1'b1;
        S_EXEC: begin
          if (w_alu) begin
            Acc_we = 1'b1;
            mode   = alu_mode(w_op);
          end else if (w_op == OP_MVA) begin
            Acc_we = 1'b1;
            mode   = MODE_PASS;
          end else if (w_op == OP_MOV) begin
            RF_we = 1'b1;
          end
        end
        S_MEM0: begin
          MAR_we  = 1'b1;
          MAR_mux = MAR_MBR;
          if (w_op == OP_STA) begin
            MBR_we  = 1'b1;
            MBR_mux = MBR_ACC;
          end
        end
        S_MEM1: begin
          if (w_op == OP_LDA) MBR_we = 1'b1;
          else                RAM_we = 1'b1;
        end
        S_WB: begin
          Acc_we      = 1'b1;
          ALU_mux     = ALU_MBR;
          ALU_out_mux = AOUT_OPND;
        end
        S_JUMP: PC_ld  = 1'b1;
        S_SKIP: PC_inc = 1'b1;
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign select  = r_sel;
  assign halted  = r_halted;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: per-instruction micro-op scripts build an expected
// cycle queue that drives the inputs and is compared against the DUT each cycle.
module tb_cu_seq;

  logic       cu_clk, cu_rst, zero, carry, mem_ready;
  logic [7:0] cu_in;
  logic [2:0] mode;
  logic [1:0] select;
  logic [7:0] state;
  logic MBR_we, IR_we, PC_inc, PC_ld, RF_we, Acc_we, MAR_we, RAM_we;
  logic ALU_mux, RF_mux, ALU_out_mux, MAR_mux, MBR_mux, halted, illegal;

  cu_seq #(.DATA_W(8), .OPC_W(4), .SEL_W(2)) dut (
    .cu_clk(cu_clk), .cu_rst(cu_rst), .cu_in(cu_in), .zero(zero), .carry(carry),
    .mem_ready(mem_ready), .mode(mode), .select(select), .state(state),
    .MBR_we(MBR_we), .IR_we(IR_we), .PC_inc(PC_inc), .PC_ld(PC_ld), .RF_we(RF_we),
    .Acc_we(Acc_we), .MAR_we(MAR_we), .RAM_we(RAM_we), .ALU_mux(ALU_mux),
    .RF_mux(RF_mux), .ALU_out_mux(ALU_out_mux), .MAR_mux(MAR_mux),
    .MBR_mux(MBR_mux), .halted(halted), .illegal(illegal)
  );

  initial cu_clk = 1'b0;
  always #5 cu_clk = ~cu_clk;

  // strobe vector order: MBR_we IR_we PC_inc PC_ld RF_we Acc_we MAR_we RAM_we
  //                      ALU_mux RF_mux ALU_out_mux MAR_mux MBR_mux
  localparam logic [12:0] M_MBR  = 13'd1 << 12;
  localparam logic [12:0] M_IR   = 13'd1 << 11;
  localparam logic [12:0] M_PCI  = 13'd1 << 10;
  localparam logic [12:0] M_PCL  = 13'd1 << 9;
  localparam logic [12:0] M_RF   = 13'd1 << 8;
  localparam logic [12:0] M_ACC  = 13'd1 << 7;
  localparam logic [12:0] M_MAR  = 13'd1 << 6;
  localparam logic [12:0] M_RAM  = 13'd1 << 5;
  localparam logic [12:0] M_ALUM = 13'd1 << 4;
  localparam logic [12:0] M_RFM  = 13'd1 << 3;
  localparam logic [12:0] M_AOM  = 13'd1 << 2;
  localparam logic [12:0] M_MARM = 13'd1 << 1;
  localparam logic [12:0] M_MBRM = 13'd1 << 0;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [7:0]  din;
    logic        z;
    logic        c;
    logic [7:0]  st;
    logic [12:0] stb;
    logic [2:0]  md;
    logic [1:0]  sel;
    logic        hlt;
    logic        ill;
  } cyc_t;

  cyc_t       q[$];
  logic [1:0] m_sel;
  logic       m_ill;
  int         total, bad, n_ir, n_pcl, n;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] st, input logic [12:0] stb, input logic [2:0] md,
                      input logic rdy);
    cyc_t e;
    e.rst = 1'b0;   e.rdy = rdy;       e.din = 8'($urandom);
    e.z = 1'($urandom); e.c = 1'($urandom);
    e.st = st;      e.stb = stb;       e.md = md;
    e.sel = m_sel;  e.hlt = (st == 8'd12); e.ill = m_ill;
    q.push_back(e);
  endtask

  task automatic push_rst(input logic [7:0] st);
    cyc_t e;
    e.rst = 1'b1;   e.rdy = 1'b1;      e.din = 8'($urandom);
    e.z = 1'b0;     e.c = 1'b0;
    e.st = st;      e.stb = '0;        e.md = 3'd0;
    e.sel = m_sel;  e.hlt = (st == 8'd12); e.ill = m_ill;
    q.push_back(e);
    m_sel = 2'd0;
    m_ill = 1'b0;
  endtask

  // One instruction as the sequence of cycles it must produce.
  // w1/wo/wm: mem_ready-low cycles in the fetch, operand and data accesses.
  task automatic gen(input logic [7:0] ins, input logic z, input logic c,
                     input int w1, input int wo, input int wm, output int len);
    int         n0;
    logic [3:0] op;
    logic [12:0] m1;
    n0 = q.size();
    op = ins[7:4];
    push(8'd0, M_MAR, 3'd0, 1'($urandom));
    repeat (w1) push(8'd1, M_MBR, 3'd0, 1'b0);
    push(8'd1, M_MBR | M_PCI, 3'd0, 1'b1);
    push(8'd2, M_IR, 3'd0, 1'($urandom));
    q[q.size()-1].din = ins;
    m_sel = ins[1:0];
    push(8'd3, '0, 3'd0, 1'($urandom));
    q[q.size()-1].z = z;
    q[q.size()-1].c = c;
    if (op >= 4'h3 && op <= 4'h7) push(8'd4, M_ACC, 3'(op - 4'h3), 1'($urandom));
    else if (op == 4'h9) push(8'd4, M_ACC, 3'd5, 1'($urandom));
    else if (op == 4'h8) push(8'd4, M_RF, 3'd0, 1'($urandom));
    else if ((op == 4'hB && !z) || (op == 4'hC && !c)) push(8'd11, M_PCI, 3'd0, 1'($urandom));
    else if (op == 4'h1 || op == 4'h2 || op == 4'hA || op == 4'hB || op == 4'hC) begin
      push(8'd5, M_MAR, 3'd0, 1'($urandom));
      repeat (wo) push(8'd6, M_MBR, 3'd0, 1'b0);
      push(8'd6, M_MBR | M_PCI, 3'd0, 1'b1);
      if (op >= 4'hA) push(8'd10, M_PCL, 3'd0, 1'($urandom));
      else begin
        push(8'd7, M_MAR | M_MARM | ((op == 4'h2) ? (M_MBR | M_MBRM) : 13'd0), 3'd0,
             1'($urandom));
        m1 = (op == 4'h1) ? M_MBR : M_RAM;
        repeat (wm) push(8'd8, m1, 3'd0, 1'b0);
        push(8'd8, m1, 3'd0, 1'b1);
        if (op == 4'h1) push(8'd9, M_ACC | M_ALUM | M_AOM, 3'd0, 1'($urandom));
      end
    end else if (op == 4'hD || op == 4'hE) m_ill = 1'b1;
    len = q.size() - n0;
  endtask

  task automatic gen_halt(input int k);
    repeat (k) push(8'd12, '0, 3'd0, 1'($urandom));
  endtask

  initial begin
    logic [28:0] act, exp;
    total = 0; bad = 0; n_ir = 0; n_pcl = 0;
    cu_rst = 1'b1; mem_ready = 1'b0; cu_in = 8'h00; zero = 1'b0; carry = 1'b0;
    m_sel = 2'd0; m_ill = 1'b0;

    push_rst(8'd0);
    repeat (3) begin gen(8'h00, 0, 0, 0, 0, 0, n); check("nop_len", n, 4); end
    gen(8'h32, 0, 0, 0, 0, 0, n); check("add_r2_len", n, 5);
    gen(8'h41, 0, 0, 0, 0, 0, n);
    gen(8'h53, 0, 0, 0, 0, 0, n);
    gen(8'h60, 0, 0, 0, 0, 0, n);
    gen(8'h72, 0, 0, 0, 0, 0, n);
    gen(8'h81, 0, 0, 0, 0, 0, n); check("mov_len", n, 5);
    gen(8'h93, 0, 0, 0, 0, 0, n); check("mva_len", n, 5);
    gen(8'hB0, 1, 0, 0, 0, 0, n); check("jz_taken_len", n, 7);
    gen(8'hB0, 0, 1, 0, 0, 0, n); check("jz_not_len", n, 5);
    gen(8'hC0, 0, 1, 0, 0, 0, n); check("jc_taken_len", n, 7);
    gen(8'hC0, 1, 0, 0, 0, 0, n); check("jc_not_len", n, 5);
    gen(8'hA0, 0, 0, 0, 0, 0, n); check("jmp_len", n, 7);
    gen(8'h10, 0, 0, 0, 0, 3, n); check("lda_wait3_len", n, 12);
    gen(8'h11, 0, 0, 0, 0, 0, n); check("lda_len", n, 9);
    gen(8'h20, 0, 0, 0, 0, 0, n); check("sta_len", n, 8);
    gen(8'h00, 0, 0, 2, 0, 0, n); check("nop_wait2_len", n, 6);
    gen(8'hA1, 0, 0, 0, 1, 0, n); check("jmp_wait1_len", n, 8);
    gen(8'h22, 0, 0, 0, 0, 2, n); check("sta_wait2_len", n, 10);
    void'(q.pop_back());
    push_rst(8'd8);
    gen(8'h00, 0, 0, 0, 0, 0, n);
    gen(8'hF0, 0, 0, 0, 0, 0, n); check("hlt_len", n, 4);
    gen_halt(5);
    push_rst(8'd12);
    gen(8'hE0, 0, 0, 0, 0, 0, n);
    gen_halt(20);
    push_rst(8'd12);
    gen(8'hD5, 0, 0, 0, 0, 0, n);
    gen_halt(3);
    push_rst(8'd12);
    gen(8'h00, 0, 0, 0, 0, 0, n);

    foreach (q[i]) begin
      @(negedge cu_clk);
      cu_rst = q[i].rst; mem_ready = q[i].rdy; cu_in = q[i].din;
      zero = q[i].z; carry = q[i].c;
      #1;
      act = {state, MBR_we, IR_we, PC_inc, PC_ld, RF_we, Acc_we, MAR_we, RAM_we,
             ALU_mux, RF_mux, ALU_out_mux, MAR_mux, MBR_mux, mode, select, halted, illegal};
      exp = {q[i].st, q[i].stb, q[i].md, q[i].sel, q[i].hlt, q[i].ill};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle%0d outputs: dut=%h model=%h (model state %0d)",
                 i, act, exp, q[i].st);
      end
      if (IR_we === 1'b1) n_ir++;
      if (PC_ld === 1'b1) n_pcl++;
    end

    check("ir_we_pulses", n_ir, 26);
    check("pc_ld_pulses", n_pcl, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
